alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/opcode interface: accepts instructions over a valid/ready handshake, reads operands from an internal register file, and drives in_a/in_b/input_carry/alu_opcode into the combinational ALU.
- Captures alu_out and alu_out_flag, writes the result back to the destination register and updates a sticky flag register.
- Sits between the CPU decode stage and the ALU; uses CPU_package types (DATA_WIDTH, enum_alu_opcode_t, struct_alu_flag_t).

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instructions over valid/ready, drives operands into a
// combinational ALU, and retires the result into a local register file and sticky flags.
package CPU_package;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_MUL = 4'd2,
    ALU_OP_AND = 4'd3,
    ALU_OP_OR  = 4'd4,
    ALU_OP_XOR = 4'd5,
    ALU_OP_CPR = 4'd6
  } enum_alu_opcode_t;

  // Carry sits at bit 4 so the controller's default CARRY_BIT selects it.
  typedef struct packed {
    logic [1:0] rsvd;
    logic       overflow;
    logic       carry;
    logic       sign;
    logic       greater;
    logic       equal;
    logic       less;
  } struct_alu_flag_t;
endpackage

module alu_issue_ctrl
  import CPU_package::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_AW    = $clog2(NUM_REGS),
  parameter int CARRY_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  enum_alu_opcode_t      instr_op,
  input  logic [REG_AW-1:0]     instr_rd,
  input  logic [REG_AW-1:0]     instr_rs1,
  input  logic [REG_AW-1:0]     instr_rs2,
  input  logic                  instr_use_carry,
  input  logic                  ld_en,
  input  logic [REG_AW-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [REG_AW-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] in_a,
  output logic [DATA_WIDTH-1:0] in_b,
  output logic                  input_carry,
  output enum_alu_opcode_t      alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  struct_alu_flag_t      alu_out_flag,
  output logic                  wb_valid,
  output logic [REG_AW-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output struct_alu_flag_t      flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  struct_alu_flag_t        flags_q, flags_d;
  logic [DATA_WIDTH-1:0]   in_a_q, in_a_d, in_b_q, in_b_d;
  logic                    carry_q, carry_d;
  enum_alu_opcode_t        op_q, op_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]       wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;

  assign instr_ready = (state_q == IDLE);
  assign rd_data     = regs_q[rd_addr];
  assign in_a        = in_a_q;
  assign in_b        = in_b_q;
  assign input_carry = carry_q;
  assign alu_opcode  = op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flags       = flags_q;

  // NOTE: every _d gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    flags_d    = flags_q;
    in_a_d     = in_a_q;
    in_b_d     = in_b_q;
    carry_d    = carry_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    // Host load first so a same-cycle writeback below overrides it.
    if (ld_en) regs_d[ld_addr] = ld_data;

    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          in_a_d  = regs_q[instr_rs1];
          in_b_d  = regs_q[instr_rs2];
          carry_d = instr_use_carry ? flags_q[CARRY_BIT] : 1'b0;
          op_d    = instr_op;
          rd_d    = instr_rd;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        flags_d = alu_out_flag;
        if (op_q != ALU_OP_CPR) begin
          regs_d[rd_q] = alu_out;
          wb_valid_d   = 1'b1;
          wb_rd_d      = rd_q;
          wb_data_d    = alu_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      // NOTE: the register file is reset explicitly because software relies on zeroed regs.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q    <= '0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      carry_q    <= 1'b0;
      op_q       <= ALU_OP_ADD;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      flags_q    <= flags_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      carry_q    <= carry_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in plus a transaction-level model of
// the register file and sticky flags; directed scenarios followed by random instructions.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import CPU_package::*;

  localparam int NR = 8;
  localparam int AW = 3;
  localparam int CB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid, instr_ready;
  enum_alu_opcode_t instr_op;
  logic [AW-1:0]    instr_rd, instr_rs1, instr_rs2;
  logic             instr_use_carry;
  logic             ld_en;
  logic [AW-1:0]    ld_addr, rd_addr, wb_rd;
  logic [7:0]       ld_data, rd_data, in_a, in_b, alu_out, wb_data;
  logic             input_carry, wb_valid;
  enum_alu_opcode_t alu_opcode;
  struct_alu_flag_t alu_out_flag, flags;
  logic [15:0]      alu_res;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NUM_REGS(NR), .REG_AW(AW), .CARRY_BIT(CB)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_carry(instr_use_carry),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .in_a(in_a), .in_b(in_b), .input_carry(input_carry), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_out_flag(alu_out_flag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags)
  );

  // Returns {flags, result} for one ALU operation.
  function automatic logic [15:0] alu_ref(input enum_alu_opcode_t op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
    struct_alu_flag_t f;
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  o;
    f = '0;
    o = '0;
    case (op)
      ALU_OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        o = s[7:0]; f.carry = s[8];
        f.overflow = (a[7] == b[7]) && (o[7] != a[7]);
      end
      ALU_OP_SUB: begin
        s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        o = s[7:0]; f.carry = s[8];
        f.overflow = (a[7] != b[7]) && (o[7] != a[7]);
      end
      ALU_OP_MUL: begin
        p = a * b;
        o = p[7:0]; f.carry = |p[15:8];
      end
      ALU_OP_AND: o = a & b;
      ALU_OP_OR:  o = a | b;
      ALU_OP_XOR: o = a ^ b;
      ALU_OP_CPR: begin
        f.less = a < b; f.equal = a == b; f.greater = a > b;
      end
      default: o = '0;
    endcase
    if (op != ALU_OP_CPR) f.sign = o[7];
    return {f, o};
  endfunction

  always_comb alu_res = alu_ref(alu_opcode, in_a, in_b, input_carry);
  assign alu_out      = alu_res[7:0];
  assign alu_out_flag = struct_alu_flag_t'(alu_res[15:8]);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  m_regs [NR];
  logic [7:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; ld_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_flags = '0;
  endtask

  task automatic check_regfile(input string tag);
    for (int i = 0; i < NR; i++) begin
      rd_addr = AW'(i);
      #1;
      check(tag, rd_data, m_regs[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    check("rst_ready", instr_ready, 1);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbrd", wb_rd, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_in_a", in_a, 0);
    check("rst_in_b", in_b, 0);
    check("rst_cin", input_carry, 0);
    check("rst_op", 32'(alu_opcode), 32'(ALU_OP_ADD));
    check("rst_flags", 32'(flags), 0);
    check_regfile("rst_reg");
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  // mode 0: plain; 1: host load to rs1 during ISSUE; 2: host load to rd during CAPTURE.
  task automatic issue(input enum_alu_opcode_t op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic uc, input int mode, input bit keep_valid);
    logic [7:0]  ea, eb, ldv;
    logic        ec;
    logic [15:0] r;
    int          waits;
    waits = 0;
    while (!instr_ready && waits < 4) begin
      @(posedge clk); #1;
      waits++;
    end
    check("ready_idle", instr_ready, 1);
    ea = m_regs[rs1]; eb = m_regs[rs2];
    ec = uc ? m_flags[CB] : 1'b0;
    r  = alu_ref(op, ea, eb, ec);
    ldv = 8'($urandom);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_use_carry = uc;
    @(posedge clk); #1;
    if (!keep_valid) instr_valid = 1'b0;
    check("issue_ready", instr_ready, 0);
    check("issue_wbv", wb_valid, 0);
    check("issue_in_a", in_a, ea);
    check("issue_in_b", in_b, eb);
    check("issue_cin", input_carry, ec);
    check("issue_op", 32'(alu_opcode), 32'(op));
    if (mode == 1) begin
      ld_en = 1'b1; ld_addr = rs1; ld_data = ldv;
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (mode == 1) m_regs[rs1] = ldv;
    check("cap_ready", instr_ready, 0);
    check("cap_wbv", wb_valid, 0);
    check("cap_in_a", in_a, ea);
    if (mode == 2) begin
      ld_en = 1'b1; ld_addr = rd; ld_data = ldv;
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (mode == 2) m_regs[rd] = ldv;
    if (op != ALU_OP_CPR) m_regs[rd] = r[7:0];
    m_flags = r[15:8];
    check("wb_valid", wb_valid, (op != ALU_OP_CPR) ? 1 : 0);
    if (op != ALU_OP_CPR) begin
      check("wb_rd", wb_rd, rd);
      check("wb_data", wb_data, r[7:0]);
    end
    check("flags", 32'(flags), m_flags);
    check("hold_in_b", in_b, eb);
    rd_addr = rd;
    #1;
    check("rd_data", rd_data, m_regs[rd]);
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr_op = ALU_OP_ADD;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_use_carry = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    m_flags = '0;

    do_reset();
    check_reset_state();

    // MUL 12*2 into r3.
    load(3'd1, 8'd12); load(3'd2, 8'd2);
    issue(ALU_OP_MUL, 3'd3, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    rd_addr = 3'd3; #1;
    check("mul_r3", rd_data, 24);
    check_regfile("mul_regs");

    // Compares update flags only.
    load(3'd1, 8'd20); load(3'd2, 8'd10);
    issue(ALU_OP_CPR, 3'd5, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    check("cpr_gt", flags.greater, 1);
    load(3'd1, 8'd2);
    issue(ALU_OP_CPR, 3'd5, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    check("cpr_lt", flags.less, 1);
    load(3'd2, 8'd2);
    issue(ALU_OP_CPR, 3'd5, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    check("cpr_eq", flags.equal, 1);
    check_regfile("cpr_regs");

    // Carry in: force carry with 255+1, then 4+0 with and without use_carry.
    load(3'd1, 8'd255); load(3'd2, 8'd1); load(3'd4, 8'd4); load(3'd0, 8'd0);
    issue(ALU_OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    check("carry_set", flags[CB], 1);
    issue(ALU_OP_ADD, 3'd7, 3'd4, 3'd0, 1'b1, 0, 1'b0);
    check("adc_r7", wb_data, 5);
    issue(ALU_OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 0, 1'b0);
    issue(ALU_OP_ADD, 3'd7, 3'd4, 3'd0, 1'b0, 0, 1'b0);
    check("add_r7", wb_data, 4);

    // Dependent back-to-back chain with instr_valid held high.
    load(3'd1, 8'd7); load(3'd2, 8'd9);
    issue(ALU_OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 0, 1'b1);
    issue(ALU_OP_ADD, 3'd4, 3'd3, 3'd3, 1'b0, 0, 1'b0);
    check("chain_r4", rd_data, 32);

    // Load collisions.
    issue(ALU_OP_XOR, 3'd5, 3'd1, 3'd2, 1'b0, 2, 1'b0);
    issue(ALU_OP_SUB, 3'd6, 3'd1, 3'd2, 1'b0, 1, 1'b0);
    check_regfile("coll_regs");

    // Reset while an instruction sits in ISSUE.
    instr_valid = 1'b1; instr_op = ALU_OP_OR; instr_rd = 3'd2;
    instr_rs1 = 3'd1; instr_rs2 = 3'd4; instr_use_carry = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_flags = '0;
    check_reset_state();
    check("post_rst_wbv", wb_valid, 0);

    // Random instructions with occasional loads and collisions.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) load(AW'($urandom_range(0, NR - 1)), 8'($urandom));
      issue(enum_alu_opcode_t'($urandom_range(0, 6)), AW'($urandom_range(0, NR - 1)),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end
    check_regfile("final_regs");
    check("final_wbv", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
